// File: rtl/wfi_ctrl_pkg.sv
// Shared types and constants for the WFI sequencing logic in the Memory stage.
package wfi_ctrl_pkg;

    localparam int unsigned TIMEOUT_W_DEF = 8;
    localparam logic [1:0]  P_MODE_M      = 2'b11;

    typedef enum logic [0:0] {
        WFI_IDLE = 1'b0,
        WFI_WAIT = 1'b1
    } wfi_state_t;

    // TW only forces a timeout when running below machine mode.
    function automatic logic twActive(input logic statusTw, input logic [1:0] privMode);
        return statusTw & (privMode != P_MODE_M);
    endfunction

endpackage

// File: rtl/wfi_ctrl_if.sv
// Handshake bundle between the pipeline/trap logic and the WFI controller.
interface wfi_ctrl_if #(
    parameter int TIMEOUT_W = 8
);
    logic                 wfiM;
    logic                 InstrValidM;
    logic                 FlushW;
    logic                 TrapM;
    logic [1:0]           PrivilegeModeW;
    logic                 STATUS_TW;
    logic                 IntPendingM;
    logic [TIMEOUT_W-1:0] TimeoutLimit;
    logic                 WFIStallM;
    logic                 WFIWakeM;
    logic                 WFITimeoutFaultM;
    logic                 WFIActiveM;
    logic [TIMEOUT_W-1:0] WFICountM;

    modport master (
        output wfiM, InstrValidM, FlushW, TrapM, PrivilegeModeW, STATUS_TW,
               IntPendingM, TimeoutLimit,
        input  WFIStallM, WFIWakeM, WFITimeoutFaultM, WFIActiveM, WFICountM
    );

    modport slave (
        input  wfiM, InstrValidM, FlushW, TrapM, PrivilegeModeW, STATUS_TW,
               IntPendingM, TimeoutLimit,
        output WFIStallM, WFIWakeM, WFITimeoutFaultM, WFIActiveM, WFICountM
    );
endinterface

// File: rtl/wfi_timer.sv
// Saturating wait counter with clear/enable and an equality compare against the limit.
module wfi_timer
    import wfi_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic [TIMEOUT_W-1:0] count,
    output logic                 atLimit
);

    localparam logic [TIMEOUT_W-1:0] CNT_ZERO = {TIMEOUT_W{1'b0}};
    localparam logic [TIMEOUT_W-1:0] CNT_MAX  = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] CNT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    logic [TIMEOUT_W-1:0] count_r;

    // Count waiting cycles; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= CNT_ZERO;
        end else if (clr) begin
            count_r <= CNT_ZERO;
        end else if (en && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count   = count_r;
    assign atLimit = (count_r == limit);

endmodule

// File: rtl/wfi_ctrl.sv
// WFI sequencer: stalls Memory while waiting, then wakes on interrupt or raises a TW fault.
module wfi_ctrl
    import wfi_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    wfi_ctrl_if.slave  bus
);

    wfi_state_t           wfiState_r;
    logic                 twLatched_r;
    logic                 start_s;
    logic                 twAct_s;
    logic                 limitZero_s;
    logic                 atLimit_s;
    logic                 expire_s;
    logic                 abort_s;
    logic [TIMEOUT_W-1:0] count_s;
    logic                 stall_s;
    logic                 wake_s;
    logic                 fault_s;
    logic                 timerClr_s;
    logic                 timerEn_s;
    logic                 enterWait_s;
    logic                 leaveWait_s;

    assign start_s     = bus.wfiM & bus.InstrValidM & ~bus.TrapM & ~bus.FlushW;
    assign twAct_s     = twActive(bus.STATUS_TW, bus.PrivilegeModeW);
    assign limitZero_s = (bus.TimeoutLimit == {TIMEOUT_W{1'b0}});
    assign abort_s     = bus.FlushW | bus.TrapM;
    assign expire_s    = twLatched_r & atLimit_s;

    wfi_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (timerClr_s),
        .en      (timerEn_s),
        .limit   (bus.TimeoutLimit),
        .count   (count_s),
        .atLimit (atLimit_s)
    );

    // Per-cycle decode of stall, pulses and timer control from state and inputs.
    always_comb begin
        stall_s     = 1'b0;
        wake_s      = 1'b0;
        fault_s     = 1'b0;
        timerClr_s  = 1'b0;
        timerEn_s   = 1'b0;
        enterWait_s = 1'b0;
        leaveWait_s = 1'b0;
        case (wfiState_r)
            WFI_IDLE: begin
                if (start_s && bus.IntPendingM) begin
                    // retires as a NOP
                    stall_s = 1'b0;
                end else if (start_s && twAct_s && limitZero_s) begin
                    fault_s = 1'b1;
                end else if (start_s) begin
                    stall_s     = 1'b1;
                    timerEn_s   = 1'b1;
                    enterWait_s = 1'b1;
                end else begin
                    stall_s = 1'b0;
                end
            end
            WFI_WAIT: begin
                if (abort_s) begin
                    timerClr_s  = 1'b1;
                    leaveWait_s = 1'b1;
                end else if (bus.IntPendingM) begin
                    wake_s      = 1'b1;
                    timerClr_s  = 1'b1;
                    leaveWait_s = 1'b1;
                end else if (expire_s) begin
                    fault_s     = 1'b1;
                    timerClr_s  = 1'b1;
                    leaveWait_s = 1'b1;
                end else begin
                    stall_s   = 1'b1;
                    timerEn_s = 1'b1;
                end
            end
            default: begin
                timerClr_s  = 1'b1;
                leaveWait_s = 1'b1;
            end
        endcase
    end

    // State register; the TW decision is frozen at entry for the whole wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wfiState_r  <= WFI_IDLE;
            twLatched_r <= 1'b0;
        end else if (enterWait_s) begin
            wfiState_r  <= WFI_WAIT;
            twLatched_r <= twAct_s;
        end else if (leaveWait_s) begin
            wfiState_r  <= WFI_IDLE;
            twLatched_r <= 1'b0;
        end else begin
            wfiState_r  <= wfiState_r;
            twLatched_r <= twLatched_r;
        end
    end

    // Reset masks the combinational outputs so a held wfiM cannot stall during reset.
    assign bus.WFIStallM        = reset_n & stall_s;
    assign bus.WFIWakeM         = reset_n & wake_s;
    assign bus.WFITimeoutFaultM = reset_n & fault_s;
    assign bus.WFIActiveM       = (wfiState_r == WFI_WAIT);
    assign bus.WFICountM        = count_s;

endmodule

// File: tb/tb_wfi_ctrl.sv
// Directed-vector bench for wfi_ctrl with a queue scoreboard checked by a separate monitor.
module tb_wfi_ctrl;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    wfi_ctrl_if #(.TIMEOUT_W(8)) bus ();

    wfi_ctrl #(.TIMEOUT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic       stall;
        logic       wake;
        logic       fault;
        logic       active;
        logic [7:0] count;
        string      tag;
    } exp_t;

    exp_t       expQ[$];
    exp_t       mon;
    int         nChecks = 0;
    int         nFails  = 0;
    logic [1:0] curPriv = 2'b11;
    logic       curTw   = 1'b0;
    logic [7:0] curLim  = 8'd0;
    logic       curRstn = 1'b0;
    string      curTag  = "reset";

    // Apply one cycle of stimulus just after the edge and queue the expected outputs.
    task automatic cyc(input logic wfi, input logic intp, input logic flush, input logic trap,
                       input logic eStall, input logic eWake, input logic eFault,
                       input logic eActive, input logic [7:0] eCnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n            = curRstn;
        bus.wfiM           = wfi;
        bus.InstrValidM    = wfi;
        bus.IntPendingM    = intp;
        bus.FlushW         = flush;
        bus.TrapM          = trap;
        bus.PrivilegeModeW = curPriv;
        bus.STATUS_TW      = curTw;
        bus.TimeoutLimit   = curLim;
        e.stall  = eStall;
        e.wake   = eWake;
        e.fault  = eFault;
        e.active = eActive;
        e.count  = eCnt;
        e.tag    = curTag;
        expQ.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest expectation, away from the active edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            mon = expQ.pop_front();
            nChecks++;
            if ({bus.WFIStallM, bus.WFIWakeM, bus.WFITimeoutFaultM, bus.WFIActiveM, bus.WFICountM}
                !== {mon.stall, mon.wake, mon.fault, mon.active, mon.count}) begin
                nFails++;
                $display("FAIL %s: stall/wake/fault/active/count got %b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         mon.tag, bus.WFIStallM, bus.WFIWakeM, bus.WFITimeoutFaultM,
                         bus.WFIActiveM, bus.WFICountM,
                         mon.stall, mon.wake, mon.fault, mon.active, mon.count);
            end
        end
    end

    initial begin
        reset_n            = 1'b0;
        bus.wfiM           = 1'b0;
        bus.InstrValidM    = 1'b0;
        bus.IntPendingM    = 1'b0;
        bus.FlushW         = 1'b0;
        bus.TrapM          = 1'b0;
        bus.PrivilegeModeW = 2'b11;
        bus.STATUS_TW      = 1'b0;
        bus.TimeoutLimit   = 8'd0;

        cyc(L, L, L, L, L, L, L, L, 8'd0);
        cyc(L, L, L, L, L, L, L, L, 8'd0);
        curRstn = 1'b1;
        cyc(L, L, L, L, L, L, L, L, 8'd0);

        // M-mode with TW=1 and limit 0: TW has no effect, wakes after 10 stalled cycles.
        curTag = "m_mode_wake"; curPriv = 2'b11; curTw = 1'b1; curLim = 8'd0;
        cyc(H, L, L, L, H, L, L, L, 8'd0);
        for (int k = 1; k <= 9; k++) cyc(H, L, L, L, H, L, L, H, 8'(k));
        cyc(H, H, L, L, L, H, L, H, 8'd10);
        cyc(L, L, L, L, L, L, L, L, 8'd0);

        // S-mode TW timeout at limit 5.
        curTag = "s_mode_timeout"; curPriv = 2'b01; curTw = 1'b1; curLim = 8'd5;
        cyc(H, L, L, L, H, L, L, L, 8'd0);
        for (int k = 1; k <= 4; k++) cyc(H, L, L, L, H, L, L, H, 8'(k));
        cyc(H, L, L, L, L, L, H, H, 8'd5);
        cyc(L, L, L, L, L, L, L, L, 8'd0);

        // U-mode with zero limit faults in the start cycle without entering WAIT.
        curTag = "u_mode_zero_limit"; curPriv = 2'b00; curTw = 1'b1; curLim = 8'd0;
        cyc(H, L, L, L, L, L, H, L, 8'd0);
        cyc(L, L, L, L, L, L, L, L, 8'd0);

        // Interrupt arriving on the expiry cycle wins.
        curTag = "int_beats_expire"; curPriv = 2'b01; curTw = 1'b1; curLim = 8'd3;
        cyc(H, L, L, L, H, L, L, L, 8'd0);
        for (int k = 1; k <= 2; k++) cyc(H, L, L, L, H, L, L, H, 8'(k));
        cyc(H, H, L, L, L, H, L, H, 8'd3);
        cyc(L, L, L, L, L, L, L, L, 8'd0);

        // M-mode, TW=0: count saturates at 255 and the wait continues; flush aborts quietly.
        curTag = "saturate_flush"; curPriv = 2'b11; curTw = 1'b0; curLim = 8'd5;
        cyc(H, L, L, L, H, L, L, L, 8'd0);
        for (int k = 1; k <= 254; k++) cyc(H, L, L, L, H, L, L, H, 8'(k));
        for (int k = 0; k < 46; k++) cyc(H, L, L, L, H, L, L, H, 8'd255);
        cyc(H, L, H, L, L, L, L, H, 8'd255);
        cyc(L, L, L, L, L, L, L, L, 8'd0);

        // TrapM aborts a wait and blocks a start; a re-presented wfiM restarts from 1.
        curTag = "trap_abort_restart"; curPriv = 2'b01; curTw = 1'b1; curLim = 8'd10;
        cyc(H, L, L, L, H, L, L, L, 8'd0);
        for (int k = 1; k <= 2; k++) cyc(H, L, L, L, H, L, L, H, 8'(k));
        cyc(H, L, L, H, L, L, L, H, 8'd3);
        cyc(H, L, L, H, L, L, L, L, 8'd0);
        cyc(H, L, L, L, H, L, L, L, 8'd0);
        cyc(H, L, L, L, H, L, L, H, 8'd1);
        cyc(H, H, L, L, L, H, L, H, 8'd2);
        cyc(L, L, L, L, L, L, L, L, 8'd0);

        // Reset mid-wait at count 7, then a start with interrupt pending retires as a NOP.
        curTag = "reset_mid_wait"; curPriv = 2'b11; curTw = 1'b0; curLim = 8'd0;
        cyc(H, L, L, L, H, L, L, L, 8'd0);
        for (int k = 1; k <= 7; k++) cyc(H, L, L, L, H, L, L, H, 8'(k));
        curRstn = 1'b0;
        cyc(H, L, L, L, L, L, L, L, 8'd0);
        cyc(H, L, L, L, L, L, L, L, 8'd0);
        curRstn = 1'b1;
        curTag = "nop_after_reset";
        cyc(H, H, L, L, L, L, L, L, 8'd0);
        cyc(L, L, L, L, L, L, L, L, 8'd0);

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (expQ.size() > 0) begin
            nFails++;
            $display("FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
